adc_scan_sequencer: RTL and testbench
=====================================

Name: adc_scan_sequencer

Overview:
- Parametrised successor to the fixed 17-channel auto ADC updater.
- Round-robins an external SPI ADC front-end over NUM_CHAN mux channels. Per channel it discards DISCARD settling conversions, then averages 2^AVG_LOG2 conversions into a per-channel result register.
- Adds per-channel enable mask, per-channel commit gating (e.g. BEMF windows), configurable timeout with sticky error flags, update strobes and a scan-done pulse.
- Sits between the ADC controller and the SPI register file.

Parameters:
- NUM_CHAN, 17, number of mux channels (2..32).
- ADC_BITS, 10, conversion width.
- DISCARD, 3, settling conversions discarded per channel visit (0..15).
- AVG_LOG2, 0, log2 of conversions averaged per visit (0..4).
- TIMEOUT, 65520, cycles waited for adc_valid before aborting (≥2).
- CHAN_W, 5, channel index width; must satisfy 2^CHAN_W ≥ NUM_CHAN.

Ports:
- clk3p2M  in  1  sequencer clock.
- reset  in  1  asynchronous active-high reset.
- adc_in  in  ADC_BITS  conversion result; qualified by adc_valid.
- adc_valid  in  1  one-cycle result-valid strobe.
- chan_en  in  NUM_CHAN  per-channel scan enable.
- chan_gate  in  NUM_CHAN  per-channel commit permission, sampled at commit.
- err_clr  in  1  clears all timeout_err bits.
- adc_go  out  1  one-cycle conversion start.
- adc_chan  out  CHAN_W  channel currently selected.
- adc_data  out  NUM_CHAN*ADC_BITS  packed results; channel k occupies bits [k*ADC_BITS +: ADC_BITS].
- upd_stb  out  1  one-cycle pulse on each committed result.
- upd_chan  out  CHAN_W  channel committed; valid with upd_stb.
- scan_done  out  1  one-cycle pulse on wrap from last to first channel.
- timeout_err  out  NUM_CHAN  sticky per-channel timeout flags.

Behaviour:
- Reset (async assert, sync deassert use):
  - all outputs 0; adc_data all 0; state SETUP; channel 0.
  - conversion counter 0, accumulator 0, timeout counter 0.
- States SETUP → GO → ARM → WAIT.
  - SETUP:
    - adc_chan holds cur.
    - If chan_en[cur]=0, advance to the next channel and stay in SETUP (one cycle per skipped channel).
    - If chan_en is all zero, remain in SETUP at the current channel; adc_go never asserts.
  - GO: adc_go=1 for exactly one cycle.
  - ARM: adc_go=0; timeout counter cleared.
  - WAIT:
    - Timeout counter increments each cycle.
    - On adc_valid with n < DISCARD: discard the conversion, n++, return to SETUP on the same channel.
    - Otherwise on adc_valid: acc += zero-extended adc_in, n++.
      - If n reaches DISCARD+2^AVG_LOG2: commit, then advance.
      - Else return to SETUP on the same channel.
- adc_valid outside WAIT is ignored.
- Commit:
  - If chan_gate[cur]=1: adc_data[cur] ← acc_final >> AVG_LOG2 (truncating), and upd_stb/upd_chan pulse the next cycle.
  - If gate=0: result dropped, no strobe.
  - Either way, clear n and acc, then advance.
- Accumulator width: ADC_BITS+AVG_LOG2; overflow impossible.
- Advance: cur ← cur+1, or 0 if cur = NUM_CHAN-1, in which case scan_done pulses once.
- Timeout:
  - When the counter reaches TIMEOUT in WAIT, set timeout_err[cur], clear n and acc, and advance to the next channel.
  - adc_valid arriving in that same cycle is ignored (timeout wins).
- err_clr coincident with a new timeout: the set wins for that bit.
- Minimum conversion period is 4 cycles (valid in the first WAIT cycle).
- Reset mid-conversion: partial accumulation is lost and adc_data is cleared.

Decomposition:
- Shared package adc_pkg:
  - state encoding enum (SETUP/GO/ARM/WAIT);
  - localparams ACC_W = ADC_BITS+AVG_LOG2 and CONV_PER_VISIT;
  - default TIMEOUT constant.
- One natural sub-module, adc_chan_accum: holds the discard/average counter and accumulator, and emits done and avg_result.

Test Plan:
- NUM_CHAN=4, DISCARD=0, AVG_LOG2=0, all enabled and gated; ADC model returns 100+chan three cycles after go → adc_data = {103,102,101,100}; upd_chan order 0,1,2,3; scan_done pulses once per lap.
- DISCARD=3, AVG_LOG2=2; model returns 0,0,0,10,11,12,13 → committed value 11 (46>>2); exactly 7 go pulses per channel visit.
- chan_en=4'b0101 → only channels 0 and 2 are ever selected or go'd; chan_en=0 → adc_go stays low for 1000 cycles.
- chan_gate[1]=0 with model value 500 → adc_data[1] stays 0 and no upd_stb for channel 1; other channels update.
- TIMEOUT=20, model silent on channel 2 → timeout_err=4'b0100 after 23 cycles in GO/ARM/WAIT; scan continues at channel 3; err_clr clears the bit.
- Assert reset during channel 1 WAIT → all outputs 0 asynchronously; after release the scan restarts at channel 0 with the first go 2 cycles later.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and default constants for the ADC scan sequencer and its channel accumulator.
package adc_pkg;

  typedef enum logic [1:0] {
    StSetup,
    StGo,
    StArm,
    StWait
  } seq_state_e;

  localparam int unsigned DEF_ADC_BITS   = 10;
  localparam int unsigned DEF_DISCARD    = 3;
  localparam int unsigned DEF_AVG_LOG2   = 0;
  localparam int unsigned DEF_TIMEOUT    = 65520;
  localparam int unsigned ACC_W          = DEF_ADC_BITS + DEF_AVG_LOG2;
  localparam int unsigned CONV_PER_VISIT = DEF_DISCARD + (1 << DEF_AVG_LOG2);

  function automatic int unsigned acc_width(int unsigned adc_bits, int unsigned avg_log2);
    return adc_bits + avg_log2;
  endfunction

  function automatic int unsigned conv_per_visit(int unsigned discard, int unsigned avg_log2);
    return discard + (32'd1 << avg_log2);
  endfunction

endpackage

// File: rtl/adc_chan_accum.sv
// Per-visit conversion counter and accumulator: drops settling conversions, sums the rest and
// reports the averaged result on the conversion that completes the visit.
module adc_chan_accum
  import adc_pkg::*;
#(
  parameter int unsigned ADC_BITS = DEF_ADC_BITS,
  parameter int unsigned DISCARD  = DEF_DISCARD,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                clk3p2M,
  input  logic                reset,
  input  logic                sample,
  input  logic                clear,
  input  logic [ADC_BITS-1:0] sample_data,
  output logic                done,
  output logic [ADC_BITS-1:0] avg_result
);

  localparam int unsigned AccW = acc_width(ADC_BITS, AVG_LOG2);
  localparam int unsigned Conv = conv_per_visit(DISCARD, AVG_LOG2);
  localparam int unsigned CntW = $clog2(Conv + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic            discard;

  if (DISCARD == 0) begin : g_no_discard
    assign discard = 1'b0;
  end else begin : g_discard
    assign discard = (cnt_q < CntW'(DISCARD));
  end

  always_comb begin
    acc_sum    = acc_q + AccW'(sample_data);
    // The last conversion of a visit is never a discard since Conv > DISCARD.
    done       = sample && (cnt_q == CntW'(Conv - 1));
    avg_result = ADC_BITS'(acc_sum >> AVG_LOG2);
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    if (clear || done) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (sample) begin
      cnt_d = cnt_q + 1'b1;
      if (!discard) begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk3p2M or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin scan of an external SPI ADC over NUM_CHAN mux channels with per-channel enable,
// commit gating, conversion timeout and packed per-channel result registers.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 17,
  parameter int unsigned ADC_BITS = DEF_ADC_BITS,
  parameter int unsigned DISCARD  = DEF_DISCARD,
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CHAN_W   = 5
) (
  input  logic                         clk3p2M,
  input  logic                         reset,
  input  logic [ADC_BITS-1:0]          adc_in,
  input  logic                         adc_valid,
  input  logic [NUM_CHAN-1:0]          chan_en,
  input  logic [NUM_CHAN-1:0]          chan_gate,
  input  logic                         err_clr,
  output logic                         adc_go,
  output logic [CHAN_W-1:0]            adc_chan,
  output logic [NUM_CHAN*ADC_BITS-1:0] adc_data,
  output logic                         upd_stb,
  output logic [CHAN_W-1:0]            upd_chan,
  output logic                         scan_done,
  output logic [NUM_CHAN-1:0]          timeout_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  seq_state_e                  state_q, state_d;
  logic [CHAN_W-1:0]           cur_q, cur_d;
  logic [TmoW-1:0]             tmo_q, tmo_d;
  logic [NUM_CHAN*ADC_BITS-1:0] data_q, data_d;
  logic                        upd_stb_q, upd_stb_d;
  logic [CHAN_W-1:0]           upd_chan_q, upd_chan_d;
  logic                        scan_done_q, scan_done_d;
  logic [NUM_CHAN-1:0]         err_q, err_d, err_set;

  logic                        sample, advance, wrap, timeout, done;
  logic [ADC_BITS-1:0]         avg_result;

  adc_chan_accum #(
    .ADC_BITS (ADC_BITS),
    .DISCARD  (DISCARD),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk3p2M     (clk3p2M),
    .reset       (reset),
    .sample      (sample),
    .clear       (advance),
    .sample_data (adc_in),
    .done        (done),
    .avg_result  (avg_result)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    tmo_d       = tmo_q;
    data_d      = data_q;
    upd_stb_d   = 1'b0;
    upd_chan_d  = upd_chan_q;
    scan_done_d = 1'b0;
    err_set     = '0;
    sample      = 1'b0;
    advance     = 1'b0;
    wrap        = (cur_q == CHAN_W'(NUM_CHAN - 1));
    timeout     = (state_q == StWait) && (tmo_q == TmoW'(TIMEOUT));

    unique case (state_q)
      StSetup: begin
        // With nothing enabled the sequencer parks on the current channel.
        if (|chan_en) begin
          if (chan_en[cur_q]) state_d = StGo;
          else                advance = 1'b1;
        end
      end
      StGo: state_d = StArm;
      StArm: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (timeout) begin
          err_set[cur_q] = 1'b1;
          advance        = 1'b1;
          state_d        = StSetup;
        end else if (adc_valid) begin
          sample  = 1'b1;
          state_d = StSetup;
          if (done) begin
            advance = 1'b1;
            if (chan_gate[cur_q]) begin
              data_d[cur_q*ADC_BITS +: ADC_BITS] = avg_result;
              upd_stb_d                          = 1'b1;
              upd_chan_d                         = cur_q;
            end
          end
        end
      end
      default: state_d = StSetup;
    endcase

    if (advance) begin
      cur_d       = wrap ? '0 : cur_q + 1'b1;
      scan_done_d = wrap;
    end

    // A fresh timeout outranks a simultaneous clear for its own bit.
    err_d = (err_q & ~{NUM_CHAN{err_clr}}) | err_set;
  end

  always_ff @(posedge clk3p2M or posedge reset) begin
    if (reset) begin
      state_q     <= StSetup;
      cur_q       <= '0;
      tmo_q       <= '0;
      data_q      <= '0;
      upd_stb_q   <= 1'b0;
      upd_chan_q  <= '0;
      scan_done_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      upd_stb_q   <= upd_stb_d;
      upd_chan_q  <= upd_chan_d;
      scan_done_q <= scan_done_d;
      err_q       <= err_d;
    end
  end

  assign adc_go      = (state_q == StGo);
  assign adc_chan    = cur_q;
  assign adc_data    = data_q;
  assign upd_stb     = upd_stb_q;
  assign upd_chan    = upd_chan_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench: an ADC responder with a visit-level reference model plus scenario tasks.
module tb_adc_scan_sequencer;

  localparam int NCH  = 4;
  localparam int BITS = 10;
  localparam int DISC = 3;
  localparam int AVG  = 2;
  localparam int CONV = DISC + (1 << AVG);
  localparam int TMO  = 20;

  logic              clk3p2M = 1'b0;
  logic              reset = 1'b1;
  logic [BITS-1:0]   adc_in;
  logic              adc_valid;
  logic [NCH-1:0]    chan_en = 4'hF;
  logic [NCH-1:0]    chan_gate = 4'hF;
  logic              err_clr = 1'b0;
  logic              adc_go;
  logic [1:0]        adc_chan;
  logic [NCH*BITS-1:0] adc_data;
  logic              upd_stb;
  logic [1:0]        upd_chan;
  logic              scan_done;
  logic [NCH-1:0]    timeout_err;

  adc_scan_sequencer #(
    .NUM_CHAN (NCH),
    .ADC_BITS (BITS),
    .DISCARD  (DISC),
    .AVG_LOG2 (AVG),
    .TIMEOUT  (TMO),
    .CHAN_W   (2)
  ) dut (
    .clk3p2M     (clk3p2M),
    .reset       (reset),
    .adc_in      (adc_in),
    .adc_valid   (adc_valid),
    .chan_en     (chan_en),
    .chan_gate   (chan_gate),
    .err_clr     (err_clr),
    .adc_go      (adc_go),
    .adc_chan    (adc_chan),
    .adc_data    (adc_data),
    .upd_stb     (upd_stb),
    .upd_chan    (upd_chan),
    .scan_done   (scan_done),
    .timeout_err (timeout_err)
  );

  always #5 clk3p2M = ~clk3p2M;

  typedef struct {int ch; int val;} exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  int   exp_data [NCH];
  int   val_tab  [NCH];
  int   seq_tab  [CONV];
  int   vcount   [NCH];
  int   vsum     [NCH];
  int   mode = 1;          // 0 random, 1 per-channel constant, 2 per-visit sequence
  int   lat_min = 2;
  int   lat_max = 8;
  logic [NCH-1:0] silent = '0;

  function automatic int slice(int c);
    logic [BITS-1:0] v;
    v = adc_data[c*BITS +: BITS];
    return int'(v);
  endfunction

  // ADC front-end model. A visit to a channel is CONV consecutive conversions; the expected
  // result is the plain mean of those after the first DISC, recorded only if gated.
  initial begin : responder
    bit pend;
    int pend_cnt, pend_ch, pend_val, ch, e;
    pend = 0;
    adc_valid = 1'b0;
    adc_in = '0;
    forever begin
      @(negedge clk3p2M);
      adc_valid = 1'b0;
      if (reset) begin
        pend = 0;
        for (int c = 0; c < NCH; c++) begin
          vcount[c] = 0;
          vsum[c] = 0;
        end
      end else begin
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            pend = 0;
            adc_in = BITS'(pend_val);
            adc_valid = 1'b1;
            if (vcount[pend_ch] >= DISC) vsum[pend_ch] += pend_val;
            vcount[pend_ch]++;
            if (vcount[pend_ch] == CONV) begin
              e = vsum[pend_ch] / (1 << AVG);
              if (chan_gate[pend_ch]) begin
                expq.push_back('{pend_ch, e});
                exp_data[pend_ch] = e;
              end
              vcount[pend_ch] = 0;
              vsum[pend_ch] = 0;
            end
          end
        end
        if (adc_go) begin
          ch = int'(adc_chan);
          if (silent[ch]) begin
            vcount[ch] = 0;
            vsum[ch] = 0;
          end else begin
            pend = 1;
            pend_ch = ch;
            pend_cnt = $urandom_range(lat_min, lat_max);
            case (mode)
              0:       pend_val = $urandom_range(0, (1 << BITS) - 1);
              2:       pend_val = seq_tab[vcount[ch]];
              default: pend_val = val_tab[ch];
            endcase
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    err_clr = 1'b0;
    repeat (2) @(negedge clk3p2M);
    expq.delete();
    for (int c = 0; c < NCH; c++) exp_data[c] = 0;
    @(posedge clk3p2M);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk3p2M);
    checks++;
    if (adc_go !== 1'b0 || upd_stb !== 1'b0 || scan_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses go=%b upd=%b sd=%b required 0", adc_go, upd_stb, scan_done);
    end
    checks++;
    if (adc_chan !== 2'd0 || upd_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_chan adc_chan=%0d upd_chan=%0d required 0", adc_chan, upd_chan);
    end
    checks++;
    if (adc_data !== '0 || timeout_err !== '0) begin
      errors++;
      $display("FAIL reset_regs data=%h err=%b required 0", adc_data, timeout_err);
    end
  endtask

  task automatic check_upd(input string name);
    exp_t x;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected upd chan=%0d required none", name, upd_chan);
    end else begin
      x = expq.pop_front();
      if (int'(upd_chan) !== x.ch || slice(x.ch) !== x.val) begin
        errors++;
        $display("FAIL %s upd chan=%0d val=%0d required chan=%0d val=%0d", name, upd_chan,
                 slice(int'(upd_chan)), x.ch, x.val);
      end
    end
  endtask

  task automatic test_average();
    int k = 0, gocnt = 0, sd = 0;
    seq_tab = '{0, 0, 0, 10, 11, 12, 13};
    mode = 2; lat_min = 2; lat_max = 4;
    chan_en = 4'hF; chan_gate = 4'hF; silent = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000 && k < NCH; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go) gocnt++;
      if (scan_done) sd++;
      if (upd_stb) begin
        checks++;
        if (int'(upd_chan) !== k || slice(k) !== 11 || gocnt !== CONV) begin
          errors++;
          $display("FAIL avg_visit chan=%0d val=%0d gos=%0d required chan=%0d val=11 gos=%0d",
                   upd_chan, slice(int'(upd_chan)), gocnt, k, CONV);
        end
        check_upd("avg_model");
        gocnt = 0;
        k++;
      end
    end
    checks++;
    if (k !== NCH) begin
      errors++;
      $display("FAIL avg_done commits=%0d required %0d", k, NCH);
    end
    checks++;
    if (sd !== 1) begin
      errors++;
      $display("FAIL avg_scan_done pulses=%0d required 1", sd);
    end
  endtask

  task automatic test_random();
    int n = 0;
    int prev = -1;
    mode = 0; lat_min = 2; lat_max = 8;
    chan_en = 4'hF; silent = '0;
    chan_gate = 4'($urandom_range(0, 15)) | 4'b0001;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk3p2M);
      if (upd_stb) begin
        check_upd("rand_commit");
        n++;
      end
    end
    chan_en = '0;
    repeat (40) @(negedge clk3p2M);
    checks++;
    if (n < 10) begin
      errors++;
      $display("FAIL rand_count commits=%0d required >=10", n);
    end
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (slice(c) !== exp_data[c]) begin
        errors++;
        $display("FAIL rand_data ch=%0d got=%0d required %0d", c, slice(c), exp_data[c]);
      end
    end
    if (prev != -1) $display("unreachable");
  endtask

  task automatic test_enable();
    int gos = 0, bad = 0;
    mode = 1; lat_min = 2; lat_max = 5;
    val_tab = '{100, 101, 102, 103};
    chan_en = 4'b0101; chan_gate = 4'hF; silent = '0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go) begin
        gos++;
        if (adc_chan == 2'd1 || adc_chan == 2'd3) bad++;
      end
      if (upd_stb) check_upd("en_commit");
    end
    checks++;
    if (bad !== 0 || gos < 20) begin
      errors++;
      $display("FAIL en_select bad_gos=%0d gos=%0d required 0 and >=20", bad, gos);
    end
    checks++;
    if (slice(1) !== 0 || slice(3) !== 0 || slice(0) !== 100 || slice(2) !== 102) begin
      errors++;
      $display("FAIL en_data %0d %0d %0d %0d required 100 0 102 0", slice(0), slice(1),
               slice(2), slice(3));
    end
    chan_en = '0;
    do_reset();
    gos = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go || adc_chan !== 2'd0) gos++;
    end
    checks++;
    if (gos !== 0) begin
      errors++;
      $display("FAIL en_none active_cycles=%0d required 0", gos);
    end
  endtask

  task automatic test_gate();
    int n = 0;
    mode = 1; lat_min = 2; lat_max = 6;
    val_tab = '{100, 500, 102, 103};
    chan_en = 4'hF; chan_gate = 4'b1101; silent = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000 && n < 6; cyc++) begin
      @(negedge clk3p2M);
      if (upd_stb) begin
        checks++;
        if (upd_chan === 2'd1) begin
          errors++;
          $display("FAIL gate_strobe chan=%0d required not 1", upd_chan);
        end
        check_upd("gate_commit");
        n++;
      end
    end
    checks++;
    if (n !== 6 || slice(1) !== 0 || slice(0) !== 100 || slice(3) !== 103) begin
      errors++;
      $display("FAIL gate_data n=%0d d1=%0d d0=%0d d3=%0d required 6 0 100 103", n, slice(1),
               slice(0), slice(3));
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 0;
    mode = 1; lat_min = 2; lat_max = 8;
    val_tab = '{100, 101, 102, 103};
    chan_en = 4'hF; chan_gate = 4'hF; silent = 4'b0100;
    do_reset();
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go && adc_chan == 2'd2) seen = 1;
    end
    for (int cyc = 0; cyc < 100 && seen && timeout_err == '0; cyc++) begin
      @(negedge clk3p2M);
      cnt++;
    end
    checks++;
    if (!seen || cnt !== 23 || timeout_err !== 4'b0100) begin
      errors++;
      $display("FAIL tmo_set seen=%0d cycles=%0d err=%b required 1 23 0100", seen, cnt,
               timeout_err);
    end
    seen = 0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go) seen = 1;
    end
    checks++;
    if (!seen || adc_chan !== 2'd3) begin
      errors++;
      $display("FAIL tmo_next seen=%0d chan=%0d required 1 3", seen, adc_chan);
    end
    err_clr = 1'b1;
    @(negedge clk3p2M);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== '0) begin
      errors++;
      $display("FAIL tmo_clear err=%b required 0000", timeout_err);
    end
    silent = '0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    mode = 1; lat_min = 8; lat_max = 8;
    val_tab = '{100, 101, 102, 103};
    chan_en = 4'hF; chan_gate = 4'hF; silent = '0;
    do_reset();
    for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
      @(negedge clk3p2M);
      if (adc_go && adc_chan == 2'd1) seen = 1;
    end
    repeat (4) @(negedge clk3p2M);
    checks++;
    if (!seen || slice(0) !== 100) begin
      errors++;
      $display("FAIL mid_pre seen=%0d d0=%0d required 1 100", seen, slice(0));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (adc_data !== '0 || adc_chan !== 2'd0 || adc_go !== 1'b0 || upd_stb !== 1'b0 ||
        scan_done !== 1'b0 || timeout_err !== '0 || upd_chan !== 2'd0) begin
      errors++;
      $display("FAIL mid_async data=%h chan=%0d go=%b required all 0", adc_data, adc_chan,
               adc_go);
    end
    repeat (2) @(negedge clk3p2M);
    expq.delete();
    @(posedge clk3p2M);
    #1 reset = 1'b0;
    @(negedge clk3p2M);
    checks++;
    if (adc_go !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup go=%b required 0", adc_go);
    end
    @(negedge clk3p2M);
    checks++;
    if (adc_go !== 1'b1 || adc_chan !== 2'd0) begin
      errors++;
      $display("FAIL mid_restart go=%b chan=%0d required 1 0", adc_go, adc_chan);
    end
  endtask

  initial begin
    test_reset();
    test_average();
    test_random();
    test_enable();
    test_gate();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
